// File: rtl/sum_unit.sv
// ---------------------------------------------------------------------------
// sum_unit -- final sum stage of the parameterised carry-lookahead adder.
//
// Produces S = P XOR C bit by bit and passes the result, together with a
// valid flag, through a D-stage register pipeline so that the adder latency
// can be balanced against the carry network. D = 0 gives a purely
// combinational path with no registers.
//
// Parameters:
//   N  operand width in bits (N >= 1)
//   D  latency in clock cycles / number of register stages (D >= 0)
//
// Ports:
//   clk        rising-edge clock (unused when D = 0)
//   rst        asynchronous active-high reset (unused when D = 0)
//   P          propagate bits, P[i] = A[i] ^ B[i]
//   C          carry into each bit position, C[0] = adder carry-in
//   in_valid   P/C are valid this cycle
//   S          sum bits
//   out_valid  S is valid this cycle
// ---------------------------------------------------------------------------
module sum_unit #(
    parameter int N = 4,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] P,
    input  logic [N-1:0] C,
    input  logic         in_valid,
    output logic [N-1:0] S,
    output logic         out_valid
);

    // XOR is done ahead of the first register so only the sum is stored.
    logic [N-1:0] sum_next;
    assign sum_next = P ^ C;

    generate
        if (D == 0) begin : g_comb
            assign S         = sum_next;
            assign out_valid = in_valid;

            // Clock and reset have no load in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
        end else begin : g_pipe
            // Chain taps: index 0 is the stage input, index gi+1 is the
            // output of register stage gi.
            logic [N-1:0] stage_data  [0:D];
            logic         stage_valid [0:D];

            assign stage_data[0]  = sum_next;
            assign stage_valid[0] = in_valid;

            for (genvar gi = 0; gi < D; gi++) begin : g_stage
                logic [N-1:0] data_reg;
                logic         valid_reg;

                // Data captures every edge; valid only qualifies it, so
                // there is no enable and no backpressure.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        data_reg  <= '0;
                        valid_reg <= 1'b0;
                    end else begin
                        data_reg  <= stage_data[gi];
                        valid_reg <= stage_valid[gi];
                    end
                end

                assign stage_data[gi+1]  = data_reg;
                assign stage_valid[gi+1] = valid_reg;
            end

            assign S         = stage_data[D];
            assign out_valid = stage_valid[D];
        end
    endgenerate

endmodule

// File: tb/tb_sum_unit.sv
// ---------------------------------------------------------------------------
// tb_sum_unit -- self-checking bench for sum_unit.
// Four instances: N=4/D=1, N=4/D=3, N=4/D=0 and N=16/D=2.
// ---------------------------------------------------------------------------
module tb_sum_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // D=1, N=4
    logic [3:0]  p1 = '0, c1 = '0, s1;
    logic        v1 = 1'b0, ov1;
    // D=3, N=4
    logic [3:0]  p3 = '0, c3 = '0, s3;
    logic        v3 = 1'b0, ov3;
    // D=0, N=4
    logic [3:0]  p0 = '0, c0 = '0, s0;
    logic        v0 = 1'b0, ov0;
    // D=2, N=16
    logic [15:0] p16 = '0, c16 = '0, s16;
    logic        v16 = 1'b0, ov16;

    sum_unit #(.N(4), .D(1)) u_d1 (
        .clk(clk), .rst(rst), .P(p1), .C(c1), .in_valid(v1), .S(s1), .out_valid(ov1));
    sum_unit #(.N(4), .D(3)) u_d3 (
        .clk(clk), .rst(rst), .P(p3), .C(c3), .in_valid(v3), .S(s3), .out_valid(ov3));
    sum_unit #(.N(4), .D(0)) u_d0 (
        .clk(clk), .rst(rst), .P(p0), .C(c0), .in_valid(v0), .S(s0), .out_valid(ov0));
    sum_unit #(.N(16), .D(2)) u_w16 (
        .clk(clk), .rst(rst), .P(p16), .C(c16), .in_valid(v16), .S(s16), .out_valid(ov16));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: every sampled (valid, P^C) pair since reset release
    // is remembered in order; the output after an edge is the pair sampled
    // D edges earlier (counting the current one), or zero if none exists.
    logic [4:0]  hist3[$];
    logic [16:0] hist16[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist3.delete();
            hist16.delete();
        end else begin
            hist3.push_back({v3, p3 ^ c3});
            hist16.push_back({v16, p16 ^ c16});
        end
    end

    function automatic logic [4:0] model3();
        if (hist3.size() >= 3) return hist3[hist3.size()-3];
        return '0;
    endfunction

    function automatic logic [16:0] model16();
        if (hist16.size() >= 2) return hist16[hist16.size()-2];
        return '0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] p;
        logic [3:0] c;
        logic [3:0] s;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  pc;
        logic [4:0]  e3;
        logic [16:0] e16;

        vecs[0] = '{p: 4'b1010, c: 4'b0110, s: 4'b1100};
        vecs[1] = '{p: 4'hF,    c: 4'hF,    s: 4'h0};
        vecs[2] = '{p: 4'h0,    c: 4'h9,    s: 4'h9};
        vecs[3] = '{p: 4'h7,    c: 4'h0,    s: 4'h7};
        vecs[4] = '{p: 4'h0,    c: 4'h0,    s: 4'h0};
        vecs[5] = '{p: 4'h3,    c: 4'hE,    s: 4'hD};

        // ---- Reset state: nonzero valid inputs must not leak through ----
        p1 = 4'hF; v1 = 1'b1; p3 = 4'hA; v3 = 1'b1; p16 = 16'h1234; v16 = 1'b1;
        #12;
        chk("rst_s_d1", {28'd0, s1}, 32'd0);
        chk("rst_v_d1", {31'd0, ov1}, 32'd0);
        chk("rst_s_d3", {28'd0, s3}, 32'd0);
        chk("rst_v_d3", {31'd0, ov3}, 32'd0);
        chk("rst_s_w16", {16'd0, s16}, 32'd0);
        chk("rst_v_w16", {31'd0, ov16}, 32'd0);
        v3 = 1'b0; p3 = '0; v16 = 1'b0; p16 = '0;
        @(negedge clk);
        rst = 1'b0;

        // ---- Exhaustive sweep, D=1 ----
        for (int i = 0; i < 256; i++) begin
            pc = i[7:0];
            p1 = pc[7:4]; c1 = pc[3:0]; v1 = 1'b1;
            step();
            chk($sformatf("sweep_s_%0d", i), {28'd0, s1}, {28'd0, pc[7:4] ^ pc[3:0]});
            chk($sformatf("sweep_v_%0d", i), {31'd0, ov1}, 32'd1);
        end

        // ---- Directed table, D=1 ----
        foreach (vecs[k]) begin
            p1 = vecs[k].p; c1 = vecs[k].c; v1 = 1'b1;
            step();
            chk($sformatf("dir_s_%0d", k), {28'd0, s1}, {28'd0, vecs[k].s});
            chk($sformatf("dir_v_%0d", k), {31'd0, ov1}, 32'd1);
        end
        v1 = 1'b0;
        step();
        chk("d1_valid_drop", {31'd0, ov1}, 32'd0);

        // ---- Latency, D=3 ----
        p3 = 4'h5; c3 = 4'h3; v3 = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            p3 = '0; c3 = '0; v3 = 1'b0;
            chk($sformatf("lat_v_%0d", i), {31'd0, ov3}, (i == 3) ? 32'd1 : 32'd0);
            chk($sformatf("lat_s_%0d", i), {28'd0, s3}, (i == 3) ? 32'h6 : 32'h0);
        end

        // ---- Async reset with results in flight, D=3 ----
        p3 = 4'h1; c3 = 4'h0; v3 = 1'b1;
        step();
        p3 = 4'h2;
        step();
        p3 = 4'h4;
        step();
        v3 = 1'b0; p3 = '0;
        chk("inflight_v", {31'd0, ov3}, 32'd1);
        chk("inflight_s", {28'd0, s3}, 32'h1);
        #3 rst = 1'b1;
        #1;
        chk("arst_s_now", {28'd0, s3}, 32'd0);
        chk("arst_v_now", {31'd0, ov3}, 32'd0);
        step();
        chk("arst_v_edge", {31'd0, ov3}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("lost_v_%0d", i), {31'd0, ov3}, 32'd0);
        end
        p3 = 4'hA; c3 = 4'h3; v3 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            p3 = '0; c3 = '0; v3 = 1'b0;
            chk($sformatf("post_v_%0d", i), {31'd0, ov3}, (i == 3) ? 32'd1 : 32'd0);
            chk($sformatf("post_s_%0d", i), {28'd0, s3}, (i == 3) ? 32'h9 : 32'h0);
        end

        // ---- Random traffic on D=3 against the history model ----
        for (int i = 0; i < 200; i++) begin
            p3 = 4'($urandom); c3 = 4'($urandom); v3 = 1'($urandom);
            step();
            e3 = model3();
            chk($sformatf("rnd3_s_%0d", i), {28'd0, s3}, {28'd0, e3[3:0]});
            chk($sformatf("rnd3_v_%0d", i), {31'd0, ov3}, {31'd0, e3[4]});
        end

        // ---- Combinational mode, D=0 ----
        p0 = 4'hC; c0 = 4'hA; v0 = 1'b1;
        #1;
        chk("d0_s", {28'd0, s0}, 32'h6);
        chk("d0_v_hi", {31'd0, ov0}, 32'd1);
        v0 = 1'b0; c0 = 4'h0;
        #1;
        chk("d0_v_lo", {31'd0, ov0}, 32'd0);
        chk("d0_s_p", {28'd0, s0}, 32'hC);

        // ---- Width scaling, N=16 D=2 ----
        p16 = 16'hFFFF; c16 = 16'h8001; v16 = 1'b1;
        step();
        p16 = '0; c16 = '0; v16 = 1'b0;
        chk("w16_v_early", {31'd0, ov16}, 32'd0);
        step();
        chk("w16_dir_s", {16'd0, s16}, 32'h7FFE);
        chk("w16_dir_v", {31'd0, ov16}, 32'd1);
        for (int i = 0; i < 1000; i++) begin
            p16 = 16'($urandom); c16 = 16'($urandom); v16 = 1'($urandom);
            step();
            e16 = model16();
            chk($sformatf("rnd16_s_%0d", i), {16'd0, s16}, {16'd0, e16[15:0]});
            chk($sformatf("rnd16_v_%0d", i), {31'd0, ov16}, {31'd0, e16[16]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
